// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter FSM states,
// the transmitter start-acknowledge window, and index-width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        HOLD
    } arb_state_e;

    // Cycles allowed between tx_transmit and tx_busy rising before the
    // transmitter is presumed dead.
    localparam int unsigned BUSY_WAIT_LIMIT = 4;

    // Width of an index into a vector of n entries (never below one bit).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin picker: first set bit of valid at or after ptr, wrapping
// from the top entry back to entry 0.
module rr_select
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant_onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Walk the candidates in priority order starting at ptr; keep the first hit.
    always_comb begin
        any          = 1'b0;
        idx          = '0;
        sum          = '0;
        cand         = '0;
        grant_onehot = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(N_REQ)) begin
                sum = sum - (IDX_W + 1)'(N_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (!any && valid[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
        if (any) begin
            grant_onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level arbiter that multiplexes N_REQ byte streams onto a single
// uart_tx. Ownership is held for a whole packet (until a byte with
// req_last), or revoked after HOLD_TIMEOUT idle cycles mid-packet.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ        = 2,
    parameter int unsigned UART_WIDTH   = 8,
    parameter int unsigned HOLD_TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        arstn,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*UART_WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    output logic [UART_WIDTH-1:0]       tx_data,
    output logic                        tx_transmit,
    input  logic                        tx_busy,
    output logic [N_REQ-1:0]            grant,
    output logic                        timeout_err
);

    localparam int unsigned IDX_W  = idx_width(N_REQ);
    localparam int unsigned HOLD_W = $clog2(HOLD_TIMEOUT + 1);
    localparam int unsigned BUSY_W = idx_width(BUSY_WAIT_LIMIT);

    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_TIMEOUT);
    localparam logic [BUSY_W-1:0] BUSY_LAST = BUSY_W'(BUSY_WAIT_LIMIT - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);

    arb_state_e              state_q,    state_d;
    logic [N_REQ-1:0]        grant_q,    grant_d;
    logic [IDX_W-1:0]        owner_q,    owner_d;
    logic [IDX_W-1:0]        rr_ptr_q,   rr_ptr_d;
    logic [UART_WIDTH-1:0]   tx_data_q,  tx_data_d;
    logic                    last_q,     last_d;
    logic [HOLD_W-1:0]       hold_cnt_q, hold_cnt_d;
    logic [BUSY_W-1:0]       busy_cnt_q, busy_cnt_d;

    logic [N_REQ-1:0]        sel_onehot;
    logic [IDX_W-1:0]        sel_idx;
    logic                    sel_any;

    logic                    owner_valid;
    logic                    owner_last;
    logic [UART_WIDTH-1:0]   owner_data;

    logic                    ready_en;
    logic                    transmit;
    logic                    timeout_pulse;
    logic                    byte_done;
    logic                    release_grant;

    rr_select #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .valid        (req_valid),
        .ptr          (rr_ptr_q),
        .grant_onehot (sel_onehot),
        .idx          (sel_idx),
        .any          (sel_any)
    );

    // View of the current owner's request lane; grant_q is one-hot or zero.
    always_comb begin
        owner_valid = |(req_valid & grant_q);
        owner_last  = |(req_last & grant_q);
        owner_data  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_q[i]) begin
                owner_data = req_data[i*UART_WIDTH +: UART_WIDTH];
            end
        end
    end

    // Next-state and strobe decode for the packet arbitration FSM.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        tx_data_d     = tx_data_q;
        last_d        = last_q;
        hold_cnt_d    = hold_cnt_q;
        busy_cnt_d    = busy_cnt_q;
        ready_en      = 1'b0;
        transmit      = 1'b0;
        timeout_pulse = 1'b0;
        byte_done     = 1'b0;
        release_grant = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    grant_d = sel_onehot;
                    owner_d = sel_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (owner_valid) begin
                    ready_en  = 1'b1;
                    tx_data_d = owner_data;
                    last_d    = owner_last;
                    state_d   = START;
                end else begin
                    hold_cnt_d = '0;
                    state_d    = HOLD;
                end
            end
            START: begin
                transmit   = 1'b1;
                busy_cnt_d = '0;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (busy_cnt_q == BUSY_LAST) begin
                    timeout_pulse = 1'b1;
                    byte_done     = 1'b1;
                end else begin
                    busy_cnt_d = busy_cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    byte_done = 1'b1;
                end
            end
            HOLD: begin
                if (hold_cnt_q != HOLD_MAX) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
                if (owner_valid) begin
                    state_d = LOAD;
                end else if (hold_cnt_q == HOLD_MAX) begin
                    timeout_pulse = 1'b1;
                    release_grant = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A finished byte (real or presumed after a missing busy) either
        // continues the packet or ends ownership.
        if (byte_done) begin
            if (last_q) begin
                release_grant = 1'b1;
            end else begin
                state_d = LOAD;
            end
        end

        if (release_grant) begin
            grant_d  = '0;
            state_d  = IDLE;
            rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            tx_data_q  <= '0;
            last_q     <= 1'b0;
            hold_cnt_q <= '0;
            busy_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign req_ready   = {N_REQ{ready_en}} & grant_q;
    assign tx_transmit = transmit;
    assign tx_data     = tx_data_q;
    assign grant       = grant_q;
    assign timeout_err = timeout_pulse;

endmodule
